// File: rtl/trellis_memory_param.sv
// Survivor-path memory for a Viterbi decoder: NUM_BANKS rotating banks, one written
// ascending, the newest complete bank read descending for traceback, the oldest for decode.
module trellis_memory_param #(
    parameter int NUM_STATES = 64,
    parameter int DEPTH      = 32,
    parameter int NUM_BANKS  = 4,
    parameter int AW         = $clog2(DEPTH),
    parameter int BW         = $clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  flush,
    input  logic                  sel_valid,
    input  logic [NUM_STATES-1:0] selection,
    output logic [BW-1:0]         mem_bank,
    output logic [AW-1:0]         wr_addr,
    output logic [AW-1:0]         tb_addr,
    output logic [NUM_STATES-1:0] tb_data,
    output logic                  tb_valid,
    output logic [NUM_STATES-1:0] dec_data,
    output logic                  dec_valid,
    output logic                  block_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

    logic [NUM_STATES-1:0] r_mem [NUM_BANKS][DEPTH];

    logic [AW-1:0]         r_wr_addr;
    logic [AW-1:0]         r_tb_addr;
    logic [BW-1:0]         r_bank;
    logic [BW-1:0]         r_filled;
    logic [NUM_STATES-1:0] r_tb_data;
    logic [NUM_STATES-1:0] r_dec_data;
    logic                  r_tb_valid;
    logic                  r_dec_valid;
    logic                  r_block_done;

    logic                  w_accept;
    logic                  w_wrap;
    logic [BW-1:0]         w_tb_bank;
    logic [BW-1:0]         w_dec_bank;

    // flush outranks sel_valid, so a word presented alongside flush is dropped
    assign w_accept   = sel_valid & ~flush;
    assign w_wrap     = w_accept & (r_wr_addr == LAST_ADDR);
    assign w_tb_bank  = (r_bank == '0) ? LAST_BANK : r_bank - BW'(1);
    assign w_dec_bank = (r_bank == LAST_BANK) ? '0 : r_bank + BW'(1);

    // NOTE: the storage array has no reset; only control state and output registers
    // are cleared, which keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_bank][r_wr_addr] <= selection;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_addr    <= '0;
            r_tb_addr    <= LAST_ADDR;
            r_bank       <= '0;
            r_filled     <= '0;
            r_tb_data    <= '0;
            r_dec_data   <= '0;
            r_tb_valid   <= 1'b0;
            r_dec_valid  <= 1'b0;
            r_block_done <= 1'b0;
        end else if (flush) begin
            r_wr_addr    <= '0;
            r_tb_addr    <= LAST_ADDR;
            r_bank       <= '0;
            r_filled     <= '0;
            r_tb_valid   <= 1'b0;
            r_dec_valid  <= 1'b0;
            r_block_done <= 1'b0;
        end else if (sel_valid) begin
            // Explicit wrap compares: DEPTH need not be a power of two
            r_wr_addr    <= w_wrap ? '0 : r_wr_addr + AW'(1);
            r_tb_addr    <= w_wrap ? LAST_ADDR : r_tb_addr - AW'(1);
            if (w_wrap) begin
                r_bank <= (r_bank == LAST_BANK) ? '0 : r_bank + BW'(1);
                if (r_filled != LAST_BANK) begin
                    r_filled <= r_filled + BW'(1);
                end
            end
            r_tb_data    <= r_mem[w_tb_bank][r_tb_addr];
            r_dec_data   <= r_mem[w_dec_bank][r_tb_addr];
            r_tb_valid   <= (r_filled != '0);
            r_dec_valid  <= (r_filled == LAST_BANK);
            r_block_done <= w_wrap;
        end else begin
            r_tb_valid   <= 1'b0;
            r_dec_valid  <= 1'b0;
            r_block_done <= 1'b0;
        end
    end

    assign mem_bank   = r_bank;
    assign wr_addr    = r_wr_addr;
    assign tb_addr    = r_tb_addr;
    assign tb_data    = r_tb_data;
    assign tb_valid   = r_tb_valid;
    assign dec_data   = r_dec_data;
    assign dec_valid  = r_dec_valid;
    assign block_done = r_block_done;

endmodule

// File: tb/tb_trellis_memory_param.sv
// Scoreboard bench for trellis_memory_param: a default instance and a small
// non-power-of-two instance (DEPTH=5, NUM_BANKS=3, NUM_STATES=8), checked against a word-count model.
module tb_trellis_memory_param;

    localparam int D_A = 32;
    localparam int B_A = 4;
    localparam int D_B = 5;
    localparam int B_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush_a, sel_valid_a, flush_b, sel_valid_b;
    logic [63:0] selection_a;
    logic [7:0]  selection_b;
    logic [1:0]  mem_bank_a, mem_bank_b;
    logic [4:0]  wr_addr_a, tb_addr_a;
    logic [2:0]  wr_addr_b, tb_addr_b;
    logic [63:0] tb_data_a, dec_data_a;
    logic [7:0]  tb_data_b, dec_data_b;
    logic        tb_valid_a, dec_valid_a, block_done_a;
    logic        tb_valid_b, dec_valid_b, block_done_b;

    trellis_memory_param u_dut_a (
        .clk(clk), .RSTn(rst_n), .flush(flush_a), .sel_valid(sel_valid_a),
        .selection(selection_a), .mem_bank(mem_bank_a), .wr_addr(wr_addr_a),
        .tb_addr(tb_addr_a), .tb_data(tb_data_a), .tb_valid(tb_valid_a),
        .dec_data(dec_data_a), .dec_valid(dec_valid_a), .block_done(block_done_a)
    );

    trellis_memory_param #(.NUM_STATES(8), .DEPTH(D_B), .NUM_BANKS(B_B)) u_dut_b (
        .clk(clk), .RSTn(rst_n), .flush(flush_b), .sel_valid(sel_valid_b),
        .selection(selection_b), .mem_bank(mem_bank_b), .wr_addr(wr_addr_b),
        .tb_addr(tb_addr_b), .tb_data(tb_data_b), .tb_valid(tb_valid_b),
        .dec_data(dec_data_b), .dec_valid(dec_valid_b), .block_done(block_done_b)
    );

    typedef struct {
        int          dut;
        logic        tbv, decv, done;
        bit          chk_tb, chk_dec;
        logic [63:0] tbd, decd;
        int          bank, wr, tba;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: everything follows from the number of words accepted since reset/flush
    int          n_acc   [2];
    logic [63:0] m_mem   [2][4][32];
    bit          m_known [2][4][32];
    logic [63:0] last_tb [2], last_dec [2];
    bit          tb_known[2], dec_known[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? D_A : D_B;
    endfunction

    function automatic int banks_of(input int d);
        return (d == 0) ? B_A : B_B;
    endfunction

    function automatic logic [63:0] rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset(input int d, input bit forget_mem);
        n_acc[d]     = 0;
        last_tb[d]   = '0;
        last_dec[d]  = '0;
        tb_known[d]  = 1'b1;
        dec_known[d] = 1'b1;
        if (forget_mem) begin
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 32; a++) m_known[d][b][a] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus and push what the DUT must show after the next edge
    task automatic step(input int d, input bit v, input bit f, input logic [63:0] sel_in);
        exp_t        e;
        int          dd, bb, wa, bk, fl, ta;
        logic [63:0] sel;
        dd  = depth_of(d);
        bb  = banks_of(d);
        sel = (d == 0) ? sel_in : {56'd0, sel_in[7:0]};
        @(negedge clk);
        if (d == 0) begin
            sel_valid_a = v; flush_a = f; selection_a = sel;
        end else begin
            sel_valid_b = v; flush_b = f; selection_b = sel[7:0];
        end
        e.dut = d; e.tbv = 1'b0; e.decv = 1'b0; e.done = 1'b0;
        if (f) begin
            n_acc[d] = 0;
        end else if (v) begin
            wa = n_acc[d] % dd;
            bk = (n_acc[d] / dd) % bb;
            fl = n_acc[d] / dd;
            if (fl > bb - 1) fl = bb - 1;
            ta = dd - 1 - wa;
            last_tb[d]   = m_mem[d][(bk + bb - 1) % bb][ta];
            tb_known[d]  = m_known[d][(bk + bb - 1) % bb][ta];
            last_dec[d]  = m_mem[d][(bk + 1) % bb][ta];
            dec_known[d] = m_known[d][(bk + 1) % bb][ta];
            e.tbv  = (fl >= 1);
            e.decv = (fl >= bb - 1);
            e.done = (wa == dd - 1);
            m_mem[d][bk][wa]   = sel;
            m_known[d][bk][wa] = 1'b1;
            n_acc[d]++;
        end
        e.chk_tb  = tb_known[d];
        e.tbd     = last_tb[d];
        e.chk_dec = dec_known[d];
        e.decd    = last_dec[d];
        e.wr      = n_acc[d] % dd;
        e.bank    = (n_acc[d] / dd) % bb;
        e.tba     = dd - 1 - e.wr;
        sb_q.push_back(e);
    endtask

    // Monitor: one expected entry per stimulus cycle, compared just after the edge
    always @(posedge clk) begin
        exp_t        e;
        logic [63:0] a_tbd, a_decd, a_bank, a_wr, a_tba;
        logic        a_tbv, a_decv, a_done;
        string       p;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.dut == 0) begin
                a_tbd = tb_data_a; a_decd = dec_data_a; a_bank = 64'(mem_bank_a);
                a_wr = 64'(wr_addr_a); a_tba = 64'(tb_addr_a);
                a_tbv = tb_valid_a; a_decv = dec_valid_a; a_done = block_done_a;
                p = "A.";
            end else begin
                a_tbd = 64'(tb_data_b); a_decd = 64'(dec_data_b); a_bank = 64'(mem_bank_b);
                a_wr = 64'(wr_addr_b); a_tba = 64'(tb_addr_b);
                a_tbv = tb_valid_b; a_decv = dec_valid_b; a_done = block_done_b;
                p = "B.";
            end
            check({p, "tb_valid"},   64'(a_tbv),  64'(e.tbv));
            check({p, "dec_valid"},  64'(a_decv), 64'(e.decv));
            check({p, "block_done"}, 64'(a_done), 64'(e.done));
            check({p, "mem_bank"},   a_bank, 64'(e.bank));
            check({p, "wr_addr"},    a_wr,   64'(e.wr));
            check({p, "tb_addr"},    a_tba,  64'(e.tba));
            if (e.chk_tb)  check({p, "tb_data"},  a_tbd,  e.tbd);
            if (e.chk_dec) check({p, "dec_data"}, a_decd, e.decd);
        end
    end

    task automatic check_reset_state(input int d);
        if (d == 0) begin
            check("A.rst_mem_bank", 64'(mem_bank_a), 64'd0);
            check("A.rst_wr_addr",  64'(wr_addr_a),  64'd0);
            check("A.rst_tb_addr",  64'(tb_addr_a),  64'(D_A - 1));
            check("A.rst_data",     tb_data_a | dec_data_a, 64'd0);
            check("A.rst_flags",    64'({tb_valid_a, dec_valid_a, block_done_a}), 64'd0);
        end else begin
            check("B.rst_mem_bank", 64'(mem_bank_b), 64'd0);
            check("B.rst_wr_addr",  64'(wr_addr_b),  64'd0);
            check("B.rst_tb_addr",  64'(tb_addr_b),  64'(D_B - 1));
            check("B.rst_data",     64'(tb_data_b | dec_data_b), 64'd0);
            check("B.rst_flags",    64'({tb_valid_b, dec_valid_b, block_done_b}), 64'd0);
        end
    endtask

    // Asynchronous reset asserted between clock edges; outputs are checked before any edge
    task automatic async_reset(input int d, input bit forget_mem);
        @(negedge clk);
        sel_valid_a = 1'b0; flush_a = 1'b0; sel_valid_b = 1'b0; flush_b = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state(d);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset(d, forget_mem);
    endtask

    task automatic run_scenario(input int d);
        int dd, bb, guard;
        dd = depth_of(d);
        bb = banks_of(d);
        async_reset(d, 1'b1);
        // First block with value = index, then blocks up to the stall point in block bb+1
        for (int i = 0; i < dd; i++) step(d, 1'b1, 1'b0, 64'(i));
        while (n_acc[d] < bb * dd + dd / 3) step(d, 1'b1, 1'b0, rnd_word());
        for (int i = 0; i < 5; i++) step(d, 1'b0, 1'b0, rnd_word());
        // Continue to the second pass over bank 2, then flush alongside a valid word
        while (n_acc[d] < (bb + 2) * dd + dd / 2 + 1) step(d, 1'b1, 1'b0, rnd_word());
        step(d, 1'b1, 1'b1, rnd_word());
        // Post-flush traffic with random gaps; decode port sweeps bank 2 including the dropped slot
        guard = 0;
        while (n_acc[d] < 2 * dd + dd / 2 && guard < 2000) begin
            step(d, ($urandom_range(0, 3) != 0), 1'b0, rnd_word());
            guard++;
        end
        check("post_flush_progress", 64'(n_acc[d]), 64'(2 * dd + dd / 2));
        // Reset mid-block, then the first block must behave as after power-up
        async_reset(d, 1'b0);
        for (int i = 0; i < dd + 2; i++) step(d, 1'b1, 1'b0, 64'(i + 100));
    endtask

    initial begin
        rst_n = 1'b1;
        flush_a = 1'b0; sel_valid_a = 1'b0; selection_a = '0;
        flush_b = 1'b0; sel_valid_b = 1'b0; selection_b = '0;
        model_reset(0, 1'b1);
        model_reset(1, 1'b1);
        run_scenario(0);
        run_scenario(1);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
